// File: rtl/seg7_pkg.sv
// seg7_pkg: shared digit codes, active-low segment patterns and width helper for the scan driver
package seg7_pkg;
    localparam logic [3:0] CODE_MINUS       = 4'd10;
    localparam logic [3:0] CODE_E           = 4'd11;
    localparam logic [3:0] CODE_FIRST_BLANK = 4'd12;
    localparam logic [3:0] CODE_BLANK       = 4'd15;

    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_MINUS = 7'b1111110;
    localparam logic [6:0] SEG_E     = 7'b0110000;
    localparam logic [6:0] SEG_OFF   = 7'b1111111;

    function automatic int idx_width(int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/seg7_decode_ext.sv
// seg7_decode_ext: 4-bit digit code to active-low a..g segments, codes 12-15 blank
module seg7_decode_ext
    import seg7_pkg::*;
(
    input  logic [3:0] code,
    output logic [6:0] seg
);
    always_comb begin
        seg = SEG_OFF;
        case (code)
            4'd0:       seg = SEG_0;
            4'd1:       seg = SEG_1;
            4'd2:       seg = SEG_2;
            4'd3:       seg = SEG_3;
            4'd4:       seg = SEG_4;
            4'd5:       seg = SEG_5;
            4'd6:       seg = SEG_6;
            4'd7:       seg = SEG_7;
            4'd8:       seg = SEG_8;
            4'd9:       seg = SEG_9;
            CODE_MINUS: seg = SEG_MINUS;
            CODE_E:     seg = SEG_E;
            default:    seg = SEG_OFF;
        endcase
    end
endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: frame-synchronous multiplexed N-digit 7-segment driver with guard
// interval, leading-zero suppression, decimal points and whole-display blanking
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 100000,
    parameter int GUARD       = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    load,
    input  logic                    lz_blank,
    input  logic                    blank_all,
    output logic                    update_pending,
    output logic                    frame_done,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp
);
    localparam int IW = idx_width(NUM_DIGITS);
    localparam int PW = idx_width(REFRESH_DIV);
    localparam int DW = 4 * NUM_DIGITS;

    logic [PW-1:0]         presc_q, presc_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [DW-1:0]         pend_dig_q, pend_dig_d, sh_dig_q, sh_dig_d;
    logic [NUM_DIGITS-1:0] pend_dp_q, pend_dp_d, sh_dp_q, sh_dp_d, an_q, an_d, sup;
    logic                  upd_q, upd_d, fd_q, fd_d, dp_q, dp_d;
    logic                  slot_end, wrap, lit, lead;
    logic [6:0]            seg_q, seg_d, dec_seg;
    logic [3:0]            code;

    assign code = sh_dig_q[{idx_q, 2'b00} +: 4];

    seg7_decode_ext u_dec (
        .code (code),
        .seg  (dec_seg)
    );

    // a digit is suppressed while it and every more-significant digit are zero
    always_comb begin
        lead = lz_blank;
        sup  = '0;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            lead   = lead && (sh_dig_q[4*i +: 4] == 4'd0);
            sup[i] = lead;
        end
    end

    always_comb begin
        slot_end   = presc_q == PW'(REFRESH_DIV - 1);
        wrap       = slot_end && (idx_q == IW'(NUM_DIGITS - 1));
        presc_d    = slot_end ? '0 : presc_q + 1'b1;
        idx_d      = !slot_end ? idx_q : wrap ? '0 : idx_q + 1'b1;
        upd_d      = load || (upd_q && !wrap);
        pend_dig_d = load ? digits_in : pend_dig_q;
        pend_dp_d  = load ? dp_in : pend_dp_q;
        sh_dig_d   = (wrap && upd_q) ? pend_dig_q : sh_dig_q;
        sh_dp_d    = (wrap && upd_q) ? pend_dp_q : sh_dp_q;
        fd_d       = wrap;
        lit        = (presc_q >= PW'(GUARD)) && !blank_all && !sup[idx_q] && (code < CODE_FIRST_BLANK);
        an_d       = lit ? ~(NUM_DIGITS'(1) << idx_q) : '1;
        seg_d      = lit ? dec_seg : SEG_OFF;
        dp_d       = !(lit && sh_dp_q[idx_q]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q    <= '0;
            idx_q      <= '0;
            pend_dig_q <= '0;
            pend_dp_q  <= '0;
            sh_dig_q   <= {NUM_DIGITS{CODE_BLANK}};
            sh_dp_q    <= '0;
            upd_q      <= 1'b0;
            fd_q       <= 1'b0;
            an_q       <= '1;
            seg_q      <= SEG_OFF;
            dp_q       <= 1'b1;
        end else begin
            presc_q    <= presc_d;
            idx_q      <= idx_d;
            pend_dig_q <= pend_dig_d;
            pend_dp_q  <= pend_dp_d;
            sh_dig_q   <= sh_dig_d;
            sh_dp_q    <= sh_dp_d;
            upd_q      <= upd_d;
            fd_q       <= fd_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
            dp_q       <= dp_d;
        end
    end

    assign update_pending = upd_q;
    assign frame_done     = fd_q;
    assign an             = an_q;
    assign seg            = seg_q;
    assign dp             = dp_q;
endmodule
